uart_rx: RTL and testbench

Asynchronous serial receiver for the krv_e UART subsystem. Deserialises frames on `UART_RX` using a 16x oversampling tick from the UART baud generator. Frame format: 7 or 8 data bits, optional odd/even parity, one stop bit. Received bytes are held in a one-entry buffer with ready, parity-error and overflow status for the register interface.

---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop deserialiser feeding a
// one-entry receive buffer with ready, parity-error and overflow status.
module uart_rx (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       UART_RX,
    input  logic       rx_sample_pulse,
    input  logic       data_bits,
    input  logic       parity_en,
    input  logic       parity_odd0_even1,
    input  logic       rx_data_reg_rd,
    output logic [7:0] rx_data,
    output logic       rx_data_read_valid,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       overflow
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e     state;
    logic       rx_meta, rx_sync;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       cfg_8bit, cfg_par_en, cfg_even;
    logic       par_acc, par_fail;
    logic       rd_accept;

    assign rd_accept = rx_data_reg_rd & rx_ready;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state              <= StIdle;
            tick_cnt           <= 4'd0;
            bit_cnt            <= 3'd0;
            shift_reg          <= 8'h00;
            cfg_8bit           <= 1'b1;
            cfg_par_en         <= 1'b0;
            cfg_even           <= 1'b0;
            par_acc            <= 1'b0;
            par_fail           <= 1'b0;
            rx_data            <= 8'h00;
            rx_data_read_valid <= 1'b0;
            rx_ready           <= 1'b0;
            parity_err         <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            rx_data_read_valid <= rd_accept;
            if (rd_accept) begin
                rx_ready   <= 1'b0;
                parity_err <= 1'b0;
                overflow   <= 1'b0;
            end

            if (rx_sample_pulse) begin
                tick_cnt <= tick_cnt + 4'd1;
                unique case (state)
                    StIdle: begin
                        if (!rx_sync) begin
                            state      <= StStart;
                            tick_cnt   <= 4'd0;
                            bit_cnt    <= 3'd0;
                            shift_reg  <= 8'h00;
                            par_acc    <= 1'b0;
                            par_fail   <= 1'b0;
                            cfg_8bit   <= data_bits;
                            cfg_par_en <= parity_en;
                            cfg_even   <= parity_odd0_even1;
                        end
                    end
                    StStart: begin
                        // Mid-bit recheck rejects short glitches on the line
                        if (tick_cnt == 4'd7) begin
                            if (!rx_sync) begin
                                state    <= StData;
                                tick_cnt <= 4'd0;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end
                    StData: begin
                        if (tick_cnt == 4'd15) begin
                            shift_reg[bit_cnt] <= rx_sync;
                            par_acc            <= par_acc ^ rx_sync;
                            bit_cnt            <= bit_cnt + 3'd1;
                            if (bit_cnt == (cfg_8bit ? 3'd7 : 3'd6)) begin
                                state <= cfg_par_en ? StParity : StStop;
                            end
                        end
                    end
                    StParity: begin
                        if (tick_cnt == 4'd15) begin
                            par_fail <= par_acc ^ rx_sync ^ ~cfg_even;
                            state    <= StStop;
                        end
                    end
                    StStop: begin
                        // Completion overrides a same-cycle read of the old character
                        if (tick_cnt == 4'd15) begin
                            state      <= StIdle;
                            rx_data    <= shift_reg;
                            rx_ready   <= 1'b1;
                            parity_err <= par_fail;
                            overflow   <= rd_accept ? 1'b0 : (overflow | rx_ready);
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: reset, 8N1 with auto-drain, 7E1,
// 8O1/8E1 parity, overflow, glitch rejection and read/completion collision.
module tb_uart_rx;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       UART_RX;
    logic       rx_sample_pulse;
    logic       data_bits;
    logic       parity_en;
    logic       parity_odd0_even1;
    logic       rx_data_reg_rd;
    logic [7:0] rx_data;
    logic       rx_data_read_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       overflow;

    logic auto_rd;
    logic rd_man;
    int   checks = 0;
    int   errors = 0;
    int   rv_cnt = 0;
    int   rv0;

    assign rx_data_reg_rd = auto_rd ? rx_ready : rd_man;

    uart_rx dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .UART_RX            (UART_RX),
        .rx_sample_pulse    (rx_sample_pulse),
        .data_bits          (data_bits),
        .parity_en          (parity_en),
        .parity_odd0_even1  (parity_odd0_even1),
        .rx_data_reg_rd     (rx_data_reg_rd),
        .rx_data            (rx_data),
        .rx_data_read_valid (rx_data_read_valid),
        .rx_ready           (rx_ready),
        .parity_err         (parity_err),
        .overflow           (overflow)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (rx_data_read_valid === 1'b1) rv_cnt++;
    end

    // One sample tick every 4 ACLK
    task automatic tick_n(input int n);
        repeat (n) begin
            rx_sample_pulse = 1'b1;
            @(negedge ACLK);
            rx_sample_pulse = 1'b0;
            repeat (3) @(negedge ACLK);
        end
    endtask

    task automatic send_bit(input logic b);
        UART_RX = b;
        tick_n(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(1'b1);
        tick_n(4);
    endtask

    task automatic do_read();
        rd_man = 1'b1;
        @(negedge ACLK);
        rd_man = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", rx_data); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", rx_ready); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %b exp 0", parity_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        checks++; if (rx_data_read_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b exp 0", rx_data_read_valid); end
        data_bits = 1'b1; parity_en = 1'b0; parity_odd0_even1 = 1'b0;
        send_frame(8'h5A, 8, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL pre_rst_data got %h exp 5a", rx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL pre_rst_ready got %b exp 1", rx_ready); end
        // Partial frame, then reset in the middle of a data bit
        UART_RX = 1'b0; tick_n(16);
        UART_RX = 1'b1; tick_n(16);
        UART_RX = 1'b0; tick_n(8);
        ARESET = 1'b1; UART_RX = 1'b1;
        @(negedge ACLK);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h exp 00", rx_data); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", rx_ready); end
        checks++; if ({parity_err, overflow, rx_data_read_valid} !== 3'b000) begin
            errors++; $display("FAIL mid_rst_flags got %b exp 000", {parity_err, overflow, rx_data_read_valid}); end
        ARESET = 1'b0;
        tick_n(4);
        send_frame(8'hC3, 8, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL post_rst_data got %h exp c3", rx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", rx_ready); end
        do_read();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL post_rst_read got %b exp 0", rx_ready); end
    endtask

    task automatic test_8n1();
        data_bits = 1'b1; parity_en = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data got %h exp a5", rx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL 8n1_ready got %b exp 1", rx_ready); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL 8n1_perr got %b exp 0", parity_err); end
        rv0 = rv_cnt;
        auto_rd = 1'b1;
        repeat (4) @(negedge ACLK);
        checks++; if (rv_cnt - rv0 !== 1) begin errors++; $display("FAIL drain_pulses got %0d exp 1", rv_cnt - rv0); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %b exp 0", rx_ready); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL drain_data got %h exp a5", rx_data); end
        send_frame(8'h3C, 8, 1'b0, 1'b0);
        repeat (4) @(negedge ACLK);
        checks++; if (rv_cnt - rv0 !== 2) begin errors++; $display("FAIL drain2_pulses got %0d exp 2", rv_cnt - rv0); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL drain2_data got %h exp 3c", rx_data); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL drain2_ready got %b exp 0", rx_ready); end
        auto_rd = 1'b0;
    endtask

    task automatic test_7e1();
        data_bits = 1'b0; parity_en = 1'b1; parity_odd0_even1 = 1'b1;
        send_frame(8'h41, 7, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL 7e1_data got %h exp 41", rx_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL 7e1_perr got %b exp 0", parity_err); end
        do_read();
        // Bit 7 of the source byte is never sent in 7-bit mode
        send_frame(8'hC1, 7, 1'b1, 1'b1);
        checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL 7e1_bad_data got %h exp 41", rx_data); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL 7e1_bad_perr got %b exp 1", parity_err); end
        do_read();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL 7e1_perr_clr got %b exp 0", parity_err); end
    endtask

    task automatic test_8o1();
        data_bits = 1'b1; parity_en = 1'b1; parity_odd0_even1 = 1'b0;
        send_frame(8'h00, 8, 1'b1, 1'b1);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL 8o1_data got %h exp 00", rx_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL 8o1_perr got %b exp 0", parity_err); end
        do_read();
        parity_odd0_even1 = 1'b1;
        send_frame(8'h00, 8, 1'b1, 1'b1);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL 8e1_perr got %b exp 1", parity_err); end
        do_read();
    endtask

    task automatic test_overflow();
        data_bits = 1'b1; parity_en = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first got %b exp 0", overflow); end
        send_frame(8'h22, 8, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovf_data got %h exp 22", rx_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready got %b exp 1", rx_ready); end
        do_read();
        checks++; if (rx_data_read_valid !== 1'b1) begin errors++; $display("FAIL ovf_rv got %b exp 1", rx_data_read_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_clr got %b exp 0", rx_ready); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovf_data_kept got %h exp 22", rx_data); end
        @(negedge ACLK);
        checks++; if (rx_data_read_valid !== 1'b0) begin errors++; $display("FAIL ovf_rv_one got %b exp 0", rx_data_read_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        data_bits = 1'b1; parity_en = 1'b0;
        UART_RX = 1'b0; tick_n(4);
        UART_RX = 1'b1; tick_n(20);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready got %b exp 0", rx_ready); end
        do_read();
        checks++; if (rx_data_read_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_rv got %b exp 0", rx_data_read_valid); end
        send_frame(8'h96, 8, 1'b0, 1'b0);
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL glitch_next_data got %h exp 96", rx_data); end
        // Next frame with a read landing on the exact completion edge
        d = 8'h69;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        UART_RX = 1'b1;
        tick_n(9);
        rx_sample_pulse = 1'b1; rd_man = 1'b1;
        @(negedge ACLK);
        rx_sample_pulse = 1'b0; rd_man = 1'b0;
        checks++; if (rx_data !== 8'h69) begin errors++; $display("FAIL race_data got %h exp 69", rx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL race_ready got %b exp 1", rx_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL race_ovf got %b exp 0", overflow); end
        checks++; if (rx_data_read_valid !== 1'b1) begin errors++; $display("FAIL race_rv got %b exp 1", rx_data_read_valid); end
        @(negedge ACLK);
        checks++; if (rx_data_read_valid !== 1'b0) begin errors++; $display("FAIL race_rv_one got %b exp 0", rx_data_read_valid); end
        repeat (2) @(negedge ACLK);
        tick_n(6);
    endtask

    initial begin
        ARESET = 1'b1; UART_RX = 1'b1; rx_sample_pulse = 1'b0;
        data_bits = 1'b1; parity_en = 1'b0; parity_odd0_even1 = 1'b0;
        auto_rd = 1'b0; rd_man = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        test_reset();
        test_8n1();
        test_7e1();
        test_8o1();
        test_overflow();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
